mult_div_unit: RTL

Iterative multiply/divide unit with HI/LO result registers, sitting directly downstream of the general-purpose register file. It takes the register file's busA/busB read data as operands and runs signed or unsigned 32x32 multiply and divide over multiple clock cycles. It exposes busy for the control path's stall logic, and holds HI/LO for later MFHI/MFLO reads via the writeback mux.

---
 rtl/mult_div_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32x32 signed/unsigned multiply/divide unit with HI/LO result registers.
// Divide datapath is included only when MDU_DIV_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;

    logic                 start_ok_s;
    logic                 signed_op_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Conditional negation used to restore the sign of a result.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            cond_neg = -v;
        end else begin
            cond_neg = v;
        end
    endfunction

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     a_raw_r;
    logic                 div_zero_r;
    logic                 div_by_zero_r;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     rem_next_s;
    logic [WIDTH-1:0]     quo_next_s;

    // Restoring divide step: acc_r[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    always_comb begin
        div_shift_s = {rem_r, acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
        if (div_ge_s) begin
            rem_next_s = WIDTH'(div_shift_s - {1'b0, mcand_r});
        end else begin
            rem_next_s = div_shift_s[WIDTH-1:0];
        end
        quo_next_s = {acc_r[WIDTH-2:0], div_ge_s};
    end

    assign div_by_zero = div_by_zero_r;
    assign start_ok_s  = start;
`else
    assign div_by_zero = 1'b0;
    assign start_ok_s  = start && !op[1];
`endif

    // Operand conditioning for a new operation (MULT/DIV are the signed ops).
    always_comb begin
        signed_op_s = !op[0];
        a_mag_s     = magnitude(busA, signed_op_s);
        b_mag_s     = magnitude(busB, signed_op_s);
    end

    // Shift-add multiply step: upper half accumulates, lower half holds the shifting multiplier.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                     (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

    // Sign fix-up and result selection for the FIX cycle.
    always_comb begin
        if (neg_res_r) begin
            product_s = -acc_r;
        end else begin
            product_s = acc_r;
        end
        fix_hi_s = product_s[2*WIDTH-1:WIDTH];
        fix_lo_s = product_s[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (op_r[1]) begin
            if (div_zero_r) begin
                fix_hi_s = a_raw_r;
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_hi_s = cond_neg(rem_r, neg_rem_r);
                fix_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_res_r);
            end
        end else begin
            fix_hi_s = product_s[2*WIDTH-1:WIDTH];
            fix_lo_s = product_s[WIDTH-1:0];
        end
`endif
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= CNT_ZERO;
            op_r      <= 2'b00;
            mcand_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
`ifdef MDU_DIV_EN
            rem_r         <= {WIDTH{1'b0}};
            a_raw_r       <= {WIDTH{1'b0}};
            div_zero_r    <= 1'b0;
            div_by_zero_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MDU_DIV_EN
            div_by_zero_r <= 1'b0;
`endif
            case (state_r)
                S_IDLE: begin
                    if (mthi) begin
                        hi <= busA;
                    end
                    if (mtlo) begin
                        lo <= busA;
                    end
                    if (start_ok_s) begin
                        op_r      <= op;
                        neg_res_r <= signed_op_s && (busA[WIDTH-1] ^ busB[WIDTH-1]);
                        neg_rem_r <= signed_op_s && busA[WIDTH-1];
                        cnt_r     <= CNT_LAST;
                        busy      <= 1'b1;
                        state_r   <= S_RUN;
`ifdef MDU_DIV_EN
                        a_raw_r    <= busA;
                        rem_r      <= {WIDTH{1'b0}};
                        div_zero_r <= op[1] && (busB == {WIDTH{1'b0}});
                        if (op[1]) begin
                            mcand_r <= b_mag_s;
                            acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                        end else begin
                            mcand_r <= a_mag_s;
                            acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
                        end
`else
                        mcand_r <= a_mag_s;
                        acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
`endif
                    end
                end
                S_RUN: begin
`ifdef MDU_DIV_EN
                    if (op_r[1]) begin
                        acc_r[WIDTH-1:0] <= quo_next_s;
                        rem_r            <= rem_next_s;
                    end else begin
                        acc_r <= mul_next_s;
                    end
`else
                    acc_r <= mul_next_s;
`endif
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= S_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_FIX: begin
                    hi      <= fix_hi_s;
                    lo      <= fix_lo_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
`ifdef MDU_DIV_EN
                    div_by_zero_r <= div_zero_r;
`endif
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
